// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC in flight, drives a 1-cycle-latency
// instruction SRAM and presents the fetched word to decode through a
// valid/allowin handshake. It captures the SRAM word into a buffer on a stall
// because the SRAM does not hold its read data.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [4:0]  EXC_ADEL = 5'h04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_allowin_in,
   input  logic [31:0] id_nextPC_in,
   input  logic        wb_ClrStpJmp_in,
   input  logic [31:0] inst_sram_rdata,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   output logic        if_valid_out,
   output logic [31:0] if_PC_out,
   output logic [31:0] if_NPC_out,
   output logic [31:0] if_NNPC_out,
   output logic [31:0] if_NPC_fast_wire,
   output logic [31:0] if_Instruct_out,
   output logic        if_exception_out,
   output logic [4:0]  if_ExcCode_out,
   output logic [31:0] if_error_VAddr_out
);

   logic [31:0] pc_r;
   logic        valid_r;
   logic        boot_r;
   logic [31:0] buf_r;
   logic        held_r;
   logic        exc_r;

   logic        load;
   logic [31:0] next_addr;
   logic        next_misaligned;

   // Decide whether a new fetch starts this cycle and where it goes.
   // Flush overrides a decode stall; boot forces the reset vector.
   always_comb begin
      load            = boot_r | ~valid_r | id_allowin_in | wb_ClrStpJmp_in;
      next_addr       = boot_r ? RESET_PC : id_nextPC_in;
      next_misaligned = (next_addr[1:0] != 2'b00);
   end

   // A misaligned fetch is never sent to the SRAM; it only raises AdEL.
   assign inst_sram_en   = load & ~next_misaligned & ~rst;
   assign inst_sram_addr = next_addr;

   // PC/valid bookkeeping plus the LIVE->HELD capture of the SRAM word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r    <= 32'h0;
         valid_r <= 1'b0;
         boot_r  <= 1'b1;
         buf_r   <= 32'h0;
         held_r  <= 1'b0;
         exc_r   <= 1'b0;
      end else if (load) begin
         pc_r    <= next_addr;
         valid_r <= 1'b1;
         boot_r  <= 1'b0;
         held_r  <= 1'b0;
         exc_r   <= next_misaligned;
      end else if (valid_r && !held_r && !exc_r) begin
         buf_r  <= inst_sram_rdata;
         held_r <= 1'b1;
      end
   end

   // Outputs toward decode; the instruction word is zero while nothing is valid
   // so reset presents a clean zero regardless of SRAM bus contents.
   always_comb begin
      if_valid_out       = valid_r;
      if_PC_out          = pc_r;
      if_NPC_out         = pc_r + 32'd4;
      if_NNPC_out        = pc_r + 32'd8;
      if_NPC_fast_wire   = pc_r + 32'd4;
      if_Instruct_out    = 32'h0;
      if (valid_r && !exc_r) begin
         if_Instruct_out = held_r ? buf_r : inst_sram_rdata;
      end
      if_exception_out   = valid_r & exc_r;
      if_ExcCode_out     = if_exception_out ? EXC_ADEL : 5'h00;
      if_error_VAddr_out = if_exception_out ? pc_r : 32'h0;
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed literal scenarios, then randomized traffic
// checked every cycle against a behavioural model of the fetch stage.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   logic        clk;
   logic        rst;
   logic        id_allowin_in;
   logic [31:0] id_nextPC_in;
   logic        wb_ClrStpJmp_in;
   logic [31:0] inst_sram_rdata;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic        if_valid_out;
   logic [31:0] if_PC_out;
   logic [31:0] if_NPC_out;
   logic [31:0] if_NNPC_out;
   logic [31:0] if_NPC_fast_wire;
   logic [31:0] if_Instruct_out;
   logic        if_exception_out;
   logic [4:0]  if_ExcCode_out;
   logic [31:0] if_error_VAddr_out;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   if_stage dut (
      .clk                (clk),
      .rst                (rst),
      .id_allowin_in      (id_allowin_in),
      .id_nextPC_in       (id_nextPC_in),
      .wb_ClrStpJmp_in    (wb_ClrStpJmp_in),
      .inst_sram_rdata    (inst_sram_rdata),
      .inst_sram_en       (inst_sram_en),
      .inst_sram_addr     (inst_sram_addr),
      .if_valid_out       (if_valid_out),
      .if_PC_out          (if_PC_out),
      .if_NPC_out         (if_NPC_out),
      .if_NNPC_out        (if_NNPC_out),
      .if_NPC_fast_wire   (if_NPC_fast_wire),
      .if_Instruct_out    (if_Instruct_out),
      .if_exception_out   (if_exception_out),
      .if_ExcCode_out     (if_ExcCode_out),
      .if_error_VAddr_out (if_error_VAddr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Contents of the instruction memory the random phase fetches from.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // Behavioural model: which instruction is in flight and whether it faulted.
   logic        m_boot;
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_exc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_boot  = 1'b1;
         m_valid = 1'b0;
         m_pc    = 32'h0;
         m_exc   = 1'b0;
      end else if (m_boot || !m_valid || id_allowin_in || wb_ClrStpJmp_in) begin
         // New fetch: the instruction moved on (or was flushed, or none yet).
         m_pc    = m_boot ? RESET_PC : id_nextPC_in;
         m_boot  = 1'b0;
         m_valid = 1'b1;
         m_exc   = (m_pc % 4) != 0;
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   logic        e_fetch;
   logic [31:0] e_addr;
   logic [31:0] e_inst;
   always @(negedge clk) begin
      if (chk_en) begin
         e_addr  = m_boot ? RESET_PC : id_nextPC_in;
         e_fetch = !rst && (m_boot || !m_valid || id_allowin_in || wb_ClrStpJmp_in)
                   && (e_addr % 4 == 0);
         e_inst  = (m_valid && !m_exc) ? mem(m_pc) : 32'h0;
         chk("en", {31'h0, inst_sram_en}, {31'h0, e_fetch});
         chk("addr", inst_sram_addr, e_addr);
         chk("valid", {31'h0, if_valid_out}, {31'h0, m_valid});
         chk("pc", if_PC_out, m_pc);
         chk("npc", if_NPC_out, m_pc + 4);
         chk("nnpc", if_NNPC_out, m_pc + 8);
         chk("npc_fast", if_NPC_fast_wire, m_pc + 4);
         if (m_valid) chk("inst", if_Instruct_out, e_inst);
         chk("exc", {31'h0, if_exception_out}, {31'h0, m_valid && m_exc});
         chk("exccode", {27'h0, if_ExcCode_out}, (m_valid && m_exc) ? 32'h4 : 32'h0);
         chk("vaddr", if_error_VAddr_out, (m_valid && m_exc) ? m_pc : 32'h0);
      end
   end

   logic        s_en;
   logic [31:0] s_addr;
   int          r;

   initial begin
      rst             = 1'b1;
      id_allowin_in   = 1'b0;
      id_nextPC_in    = 32'h0;
      wb_ClrStpJmp_in = 1'b0;
      inst_sram_rdata = 32'h0;
      tick();
      tick();
      // Reset values
      chk("rst_valid", {31'h0, if_valid_out}, 32'h0);
      chk("rst_pc", if_PC_out, 32'h0);
      chk("rst_npc", if_NPC_out, 32'h4);
      chk("rst_nnpc", if_NNPC_out, 32'h8);
      chk("rst_fast", if_NPC_fast_wire, 32'h4);
      chk("rst_inst", if_Instruct_out, 32'h0);
      chk("rst_exc", {31'h0, if_exception_out}, 32'h0);
      chk("rst_code", {27'h0, if_ExcCode_out}, 32'h0);
      chk("rst_vaddr", if_error_VAddr_out, 32'h0);
      chk("rst_en", {31'h0, inst_sram_en}, 32'h0);

      // Cycle 0: first request to the reset vector
      rst = 1'b0;
      #1;
      chk("boot_en", {31'h0, inst_sram_en}, 32'h1);
      chk("boot_addr", inst_sram_addr, 32'hBFC0_0000);
      tick();
      // Cycle 1: first instruction out, streaming next
      inst_sram_rdata = 32'h2402_0001;
      id_allowin_in   = 1'b1;
      id_nextPC_in    = if_NPC_fast_wire;
      #1;
      chk("c1_valid", {31'h0, if_valid_out}, 32'h1);
      chk("c1_pc", if_PC_out, 32'hBFC0_0000);
      chk("c1_npc", if_NPC_out, 32'hBFC0_0004);
      chk("c1_nnpc", if_NNPC_out, 32'hBFC0_0008);
      chk("c1_inst", if_Instruct_out, 32'h2402_0001);
      chk("c1_addr", inst_sram_addr, 32'hBFC0_0004);
      chk("c1_en", {31'h0, inst_sram_en}, 32'h1);
      tick();
      // Cycle 2: second instruction, decode stalls from here
      inst_sram_rdata = 32'h8C43_0000;
      id_allowin_in   = 1'b0;
      id_nextPC_in    = if_NPC_fast_wire;
      #1;
      chk("c2_pc", if_PC_out, 32'hBFC0_0004);
      chk("c2_inst", if_Instruct_out, 32'h8C43_0000);
      chk("c2_en", {31'h0, inst_sram_en}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         inst_sram_rdata = 32'hDEAD_BEEF;
         #1;
         chk("stall_inst", if_Instruct_out, 32'h8C43_0000);
         chk("stall_en", {31'h0, inst_sram_en}, 32'h0);
         chk("stall_pc", if_PC_out, 32'hBFC0_0004);
      end
      tick();
      // Release: held word still shown, one load to id_nextPC
      id_allowin_in = 1'b1;
      id_nextPC_in  = 32'h8000_1000;
      #1;
      chk("rel_inst", if_Instruct_out, 32'h8C43_0000);
      chk("rel_en", {31'h0, inst_sram_en}, 32'h1);
      chk("rel_addr", inst_sram_addr, 32'h8000_1000);
      tick();
      inst_sram_rdata = 32'h1111_2222;
      id_allowin_in   = 1'b0;
      #1;
      chk("c6_pc", if_PC_out, 32'h8000_1000);
      chk("c6_inst", if_Instruct_out, 32'h1111_2222);
      tick();
      // Flush while HELD and stalled
      inst_sram_rdata = 32'hCAFE_F00D;
      wb_ClrStpJmp_in = 1'b1;
      id_nextPC_in    = 32'hBFC0_0380;
      #1;
      chk("fl_en", {31'h0, inst_sram_en}, 32'h1);
      chk("fl_addr", inst_sram_addr, 32'hBFC0_0380);
      tick();
      wb_ClrStpJmp_in = 1'b0;
      inst_sram_rdata = 32'h4080_6000;
      id_allowin_in   = 1'b1;
      id_nextPC_in    = 32'h8000_0002;
      #1;
      chk("fl_pc", if_PC_out, 32'hBFC0_0380);
      chk("fl_inst", if_Instruct_out, 32'h4080_6000);
      chk("mis_en", {31'h0, inst_sram_en}, 32'h0);
      tick();
      // Misaligned fetch reported as AdEL
      inst_sram_rdata = 32'h5555_5555;
      id_allowin_in   = 1'b0;
      #1;
      chk("mis_valid", {31'h0, if_valid_out}, 32'h1);
      chk("mis_exc", {31'h0, if_exception_out}, 32'h1);
      chk("mis_code", {27'h0, if_ExcCode_out}, 32'h4);
      chk("mis_vaddr", if_error_VAddr_out, 32'h8000_0002);
      chk("mis_inst", if_Instruct_out, 32'h0);
      tick();
      id_allowin_in = 1'b1;
      id_nextPC_in  = 32'hFFFF_FFFC;
      #1;
      chk("mis2_exc", {31'h0, if_exception_out}, 32'h1);
      chk("wrap_en", {31'h0, inst_sram_en}, 32'h1);
      tick();
      // Address wrap-around
      id_allowin_in   = 1'b0;
      inst_sram_rdata = 32'h0000_000F;
      #1;
      chk("wrap_pc", if_PC_out, 32'hFFFF_FFFC);
      chk("wrap_npc", if_NPC_out, 32'h0);
      chk("wrap_nnpc", if_NNPC_out, 32'h4);
      chk("wrap_fast", if_NPC_fast_wire, 32'h0);
      chk("wrap_exc", {31'h0, if_exception_out}, 32'h0);
      tick();
      // Asynchronous reset between edges while HELD
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'h0, if_valid_out}, 32'h0);
      chk("arst_pc", if_PC_out, 32'h0);
      chk("arst_en", {31'h0, inst_sram_en}, 32'h0);
      chk("arst_inst", if_Instruct_out, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("rb_en", {31'h0, inst_sram_en}, 32'h1);
      chk("rb_addr", inst_sram_addr, 32'hBFC0_0000);
      tick();
      inst_sram_rdata = 32'h0BAD_CAFE;
      #1;
      chk("rb_pc", if_PC_out, 32'hBFC0_0000);
      chk("rb_inst", if_Instruct_out, 32'h0BAD_CAFE);

      // Randomized phase against the model
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         s_en   = inst_sram_en;
         s_addr = inst_sram_addr;
         @(posedge clk);
         #1;
         rst             = 1'b0;
         inst_sram_rdata = s_en ? mem(s_addr) : $urandom;
         id_allowin_in   = ($urandom_range(0, 9) < 6);
         wb_ClrStpJmp_in = ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 19);
         if (r < 15)      id_nextPC_in = if_NPC_fast_wire;
         else if (r < 18) id_nextPC_in = $urandom & 32'hFFFF_FFFC;
         else if (r < 19) id_nextPC_in = $urandom;
         else             id_nextPC_in = 32'hFFFF_FFFC;
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst = 1'b1;
         end
      end
      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
